// File: rtl/imem_boot_loader_if.sv
// Byte-stream input and instruction-memory write bus of the boot loader.
// Stream handshake: a byte moves on a rising edge where in_valid & in_ready are both 1;
// the source holds in_data stable while in_valid is high and in_ready is low.
interface imem_boot_loader_if #(
    parameter int ADDR_WIDTH = 8
);
    logic [7:0]            in_data;
    logic                  in_valid;
    logic                  in_ready;
    logic                  imem_we;
    logic [ADDR_WIDTH-1:0] imem_addr;
    logic [31:0]           imem_wdata;

    modport master (
        output in_data, in_valid,
        input  in_ready, imem_we, imem_addr, imem_wdata
    );

    modport slave (
        input  in_data, in_valid,
        output in_ready, imem_we, imem_addr, imem_wdata
    );
endinterface

// File: rtl/imem_boot_loader.sv
// Boot loader: streams a length-prefixed, XOR-checksummed image into instruction memory
// and keeps the core in reset until the checksum matches.
module imem_boot_loader #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst,
    imem_boot_loader_if.slave   bus,
    input  logic                restart,
    output logic                core_rst,
    output logic                done,
    output logic                err,
    output logic [2:0]          dbg_state_o
);
    typedef enum logic [2:0] {
        LEN_LO = 3'd0,
        LEN_HI = 3'd1,
        DATA   = 3'd2,
        CHECK  = 3'd3,
        DONE   = 3'd4,
        ERROR  = 3'd5
    } state_t;

    localparam logic [16:0] DEPTH_L = 17'(1) << ADDR_WIDTH;

    state_t                state_q, state_d;
    logic [15:0]           len_q, len_d;
    logic [1:0]            byte_cnt_q, byte_cnt_d;
    logic [ADDR_WIDTH:0]   word_cnt_q, word_cnt_d;
    logic [7:0]            csum_q, csum_d;
    logic [23:0]           lane_q, lane_d;
    logic                  in_ready_q, in_ready_d;
    logic                  imem_we_q, imem_we_d;
    logic [ADDR_WIDTH-1:0] imem_addr_q, imem_addr_d;
    logic [31:0]           imem_wdata_q, imem_wdata_d;
    logic                  core_rst_q, core_rst_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic                  accept;

    assign accept = bus.in_valid & in_ready_q;

    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        byte_cnt_d   = byte_cnt_q;
        word_cnt_d   = word_cnt_q;
        csum_d       = csum_q;
        lane_d       = lane_q;
        imem_we_d    = 1'b0;
        imem_addr_d  = imem_addr_q;
        imem_wdata_d = imem_wdata_q;

        if (restart) begin
            // restart wins over any byte accepted in the same cycle
            state_d    = LEN_LO;
            len_d      = '0;
            byte_cnt_d = '0;
            word_cnt_d = '0;
            csum_d     = '0;
            lane_d     = '0;
        end else if (accept) begin
            case (state_q)
                LEN_LO: begin
                    len_d   = {len_q[15:8], bus.in_data};
                    state_d = LEN_HI;
                end
                LEN_HI: begin
                    len_d = {bus.in_data, len_q[7:0]};
                    if (len_d == 16'd0 || {1'b0, len_d} > DEPTH_L)
                        state_d = ERROR;
                    else
                        state_d = DATA;
                end
                DATA: begin
                    csum_d     = csum_q ^ bus.in_data;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    case (byte_cnt_q)
                        2'd0: lane_d[7:0]   = bus.in_data;
                        2'd1: lane_d[15:8]  = bus.in_data;
                        2'd2: lane_d[23:16] = bus.in_data;
                        2'd3: begin
                            imem_we_d    = 1'b1;
                            imem_addr_d  = word_cnt_q[ADDR_WIDTH-1:0];
                            imem_wdata_d = {bus.in_data, lane_q};
                            word_cnt_d   = word_cnt_q + 1'b1;
                            if (16'(word_cnt_d) == len_q)
                                state_d = CHECK;
                        end
                    endcase
                end
                CHECK: state_d = (bus.in_data == csum_q) ? DONE : ERROR;
                default: ;
            endcase
        end

        // Status outputs are registered from the next state so they settle with it.
        in_ready_d = (state_d == LEN_LO) || (state_d == LEN_HI) ||
                     (state_d == DATA)   || (state_d == CHECK);
        core_rst_d = (state_d != DONE);
        done_d     = (state_d == DONE);
        err_d      = (state_d == ERROR);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= LEN_LO;
            len_q        <= '0;
            byte_cnt_q   <= '0;
            word_cnt_q   <= '0;
            csum_q       <= '0;
            lane_q       <= '0;
            in_ready_q   <= 1'b0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= '0;
            core_rst_q   <= 1'b1;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            byte_cnt_q   <= byte_cnt_d;
            word_cnt_q   <= word_cnt_d;
            csum_q       <= csum_d;
            lane_q       <= lane_d;
            in_ready_q   <= in_ready_d;
            imem_we_q    <= imem_we_d;
            imem_addr_q  <= imem_addr_d;
            imem_wdata_q <= imem_wdata_d;
            core_rst_q   <= core_rst_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.imem_we    = imem_we_q;
    assign bus.imem_addr  = imem_addr_q;
    assign bus.imem_wdata = imem_wdata_q;
    assign core_rst       = core_rst_q;
    assign done           = done_q;
    assign err            = err_q;
    assign dbg_state_o    = state_q;
endmodule

// File: tb/tb_imem_boot_loader.sv
// Bench for imem_boot_loader: drives byte images, scoreboards every memory write,
// and checks the done/err/core_rst/in_ready status after each scenario.
module tb_imem_boot_loader;
    localparam int AW    = 8;
    localparam int DEPTH = 1 << AW;

    logic       clk = 1'b0;
    logic       rst;
    logic       restart;
    logic       core_rst;
    logic       done;
    logic       err;
    logic [2:0] dbg_state;

    imem_boot_loader_if #(.ADDR_WIDTH(AW)) bus ();

    imem_boot_loader #(.ADDR_WIDTH(AW)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .restart     (restart),
        .core_rst    (core_rst),
        .done        (done),
        .err         (err),
        .dbg_state_o (dbg_state)
    );

    always #5 clk = ~clk;

    int tests_run = 0;
    int fails     = 0;
    int wr_count  = 0;

    logic [AW+31:0] exp_q[$];
    logic [AW+31:0] mon_got;
    logic [AW+31:0] mon_exp;
    logic [31:0]    img [DEPTH];

    // Scoreboard: every write strobe must match the oldest expected {addr, word}.
    always @(negedge clk) begin
        if (bus.imem_we === 1'b1) begin
            wr_count++;
            tests_run++;
            mon_got = {bus.imem_addr, bus.imem_wdata};
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL write_unexpected: got addr=%0h data=%08h, expected no write",
                         bus.imem_addr, bus.imem_wdata);
            end else begin
                mon_exp = exp_q.pop_front();
                if (mon_got !== mon_exp) begin
                    fails++;
                    $display("FAIL write_data: got addr=%0h data=%08h, expected addr=%0h data=%08h",
                             mon_got[AW+31:32], mon_got[31:0], mon_exp[AW+31:32], mon_exp[31:0]);
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        bit acc;
        int n;
        if (gaps) idle($urandom_range(0, 3));
        bus.in_data  = b;
        bus.in_valid = 1'b1;
        acc = 1'b0;
        n   = 0;
        while (!acc && n < 200) begin
            @(negedge clk);
            acc = bus.in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        bus.in_valid = 1'b0;
        if (!acc) begin
            tests_run++;
            fails++;
            $display("FAIL send_timeout: byte %02h not accepted within 200 cycles", b);
        end
    endtask

    function automatic logic [7:0] calc_csum(input int nwords);
        logic [7:0] c = 8'h00;
        for (int w = 0; w < nwords; w++)
            c = c ^ img[w][7:0] ^ img[w][15:8] ^ img[w][23:16] ^ img[w][31:24];
        return c;
    endfunction

    // Sends header + nwords payload words from img; the expected write is queued
    // before the fourth byte of each word goes out.
    task automatic send_payload(input logic [15:0] len, input int nwords, input bit gaps);
        send_byte(len[7:0], gaps);
        send_byte(len[15:8], gaps);
        for (int w = 0; w < nwords; w++) begin
            for (int k = 0; k < 4; k++) begin
                if (k == 3) exp_q.push_back({w[AW-1:0], img[w]});
                send_byte(img[w][8*k +: 8], gaps);
            end
        end
    endtask

    task automatic pulse_restart();
        restart = 1'b1;
        @(posedge clk);
        #1;
        restart = 1'b0;
    endtask

    task automatic test_reset();
        rst          = 1'b1;
        restart      = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        #12;
        tests_run++;
        if ({bus.in_ready, bus.imem_we, bus.imem_addr, bus.imem_wdata, core_rst, done, err, dbg_state}
            !== {1'b0, 1'b0, {AW{1'b0}}, 32'h0, 1'b1, 1'b0, 1'b0, 3'd0}) begin
            fails++;
            $display("FAIL reset_values: got rdy=%b we=%b addr=%0h wd=%08h crst=%b done=%b err=%b st=%0d, expected 0 0 0 0 1 0 0 0",
                     bus.in_ready, bus.imem_we, bus.imem_addr, bus.imem_wdata, core_rst, done, err, dbg_state);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        tests_run++;
        if (bus.in_ready !== 1'b0) begin
            fails++;
            $display("FAIL ready_before_edge: got %b, expected 0", bus.in_ready);
        end
        @(posedge clk);
        #1;
        tests_run++;
        if (bus.in_ready !== 1'b1) begin
            fails++;
            $display("FAIL ready_after_reset: got %b, expected 1", bus.in_ready);
        end
    endtask

    task automatic test_basic_load();
        img[0] = 32'h00500093;
        img[1] = 32'h00A00113;
        send_payload(16'd2, 2, 1'b0);
        tests_run++;
        if ({core_rst, done} !== 2'b10) begin
            fails++;
            $display("FAIL basic_before_csum: got core_rst=%b done=%b, expected 1 0", core_rst, done);
        end
        send_byte(calc_csum(2), 1'b0);
        tests_run++;
        if ({done, core_rst, err, bus.in_ready, exp_q.size() == 0} !== 5'b10001) begin
            fails++;
            $display("FAIL basic_done: got done=%b crst=%b err=%b rdy=%b pending=%0d, expected 1 0 0 0 0",
                     done, core_rst, err, bus.in_ready, exp_q.size());
        end
    endtask

    task automatic test_bad_csum_restart();
        pulse_restart();
        send_payload(16'd2, 2, 1'b0);
        send_byte(8'h00, 1'b0);
        tests_run++;
        if ({err, done, core_rst, bus.in_ready} !== 4'b1010) begin
            fails++;
            $display("FAIL bad_csum: got err=%b done=%b crst=%b rdy=%b, expected 1 0 1 0",
                     err, done, core_rst, bus.in_ready);
        end
        pulse_restart();
        tests_run++;
        if ({err, bus.in_ready, core_rst, dbg_state} !== {3'b011, 3'd0}) begin
            fails++;
            $display("FAIL restart_clear: got err=%b rdy=%b crst=%b st=%0d, expected 0 1 1 0",
                     err, bus.in_ready, core_rst, dbg_state);
        end
        send_payload(16'd2, 2, 1'b0);
        send_byte(calc_csum(2), 1'b0);
        tests_run++;
        if ({done, core_rst, err} !== 3'b100) begin
            fails++;
            $display("FAIL resend_done: got done=%b crst=%b err=%b, expected 1 0 0", done, core_rst, err);
        end
    endtask

    task automatic test_bad_len();
        logic [15:0] lens [2];
        int          w0;
        lens[0] = 16'h0000;
        lens[1] = 16'(DEPTH + 1);
        for (int i = 0; i < 2; i++) begin
            pulse_restart();
            w0 = wr_count;
            send_byte(lens[i][7:0], 1'b0);
            tests_run++;
            if (err !== 1'b0) begin
                fails++;
                $display("FAIL bad_len_lo_%0d: got err=%b, expected 0", i, err);
            end
            send_byte(lens[i][15:8], 1'b0);
            idle(3);
            tests_run++;
            if ({err, done, core_rst, bus.in_ready, wr_count == w0} !== 5'b10101) begin
                fails++;
                $display("FAIL bad_len_%0d: got err=%b done=%b crst=%b rdy=%b writes=%0d, expected 1 0 1 0 0",
                         i, err, done, core_rst, bus.in_ready, wr_count - w0);
            end
        end
    endtask

    task automatic test_full_depth();
        int w0;
        pulse_restart();
        for (int w = 0; w < DEPTH; w++) img[w] = $urandom();
        w0 = wr_count;
        send_payload(16'(DEPTH), DEPTH, 1'b0);
        send_byte(calc_csum(DEPTH), 1'b0);
        tests_run++;
        if ({done, core_rst, wr_count - w0 == DEPTH, exp_q.size() == 0} !== 4'b1011) begin
            fails++;
            $display("FAIL full_depth: got done=%b crst=%b writes=%0d pending=%0d, expected 1 0 %0d 0",
                     done, core_rst, wr_count - w0, exp_q.size(), DEPTH);
        end
    endtask

    task automatic test_gaps_and_hold();
        int w0;
        for (int w = 0; w < 8; w++) img[w] = $urandom();
        for (int pass = 0; pass < 2; pass++) begin
            pulse_restart();
            w0 = wr_count;
            send_payload(16'd8, 8, pass == 1);
            send_byte(calc_csum(8), pass == 1);
            tests_run++;
            if ({done, core_rst, wr_count - w0 == 8, exp_q.size() == 0} !== 4'b1011) begin
                fails++;
                $display("FAIL gaps_pass%0d: got done=%b crst=%b writes=%0d pending=%0d, expected 1 0 8 0",
                         pass, done, core_rst, wr_count - w0, exp_q.size());
            end
        end
        w0 = wr_count;
        bus.in_data  = 8'hA5;
        bus.in_valid = 1'b1;
        idle(10);
        tests_run++;
        if ({bus.in_ready, done, dbg_state, wr_count == w0} !== {2'b01, 3'd4, 1'b1}) begin
            fails++;
            $display("FAIL hold_after_done: got rdy=%b done=%b st=%0d writes=%0d, expected 0 1 4 0",
                     bus.in_ready, done, dbg_state, wr_count - w0);
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic test_reset_mid_load();
        pulse_restart();
        for (int w = 0; w < 2; w++) img[w] = $urandom();
        send_byte(8'd2, 1'b0);
        send_byte(8'd0, 1'b0);
        exp_q.push_back({{AW{1'b0}}, img[0]});
        for (int k = 0; k < 4; k++) send_byte(img[0][8*k +: 8], 1'b0);
        send_byte(img[1][7:0], 1'b0);
        #2;
        rst = 1'b1;
        #1;
        tests_run++;
        if ({bus.in_ready, bus.imem_we, bus.imem_addr, bus.imem_wdata, core_rst, done, err, dbg_state, exp_q.size() == 0}
            !== {1'b0, 1'b0, {AW{1'b0}}, 32'h0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b1}) begin
            fails++;
            $display("FAIL mid_load_reset: got rdy=%b we=%b addr=%0h wd=%08h crst=%b done=%b err=%b st=%0d pending=%0d, expected 0 0 0 0 1 0 0 0 0",
                     bus.in_ready, bus.imem_we, bus.imem_addr, bus.imem_wdata, core_rst, done, err, dbg_state, exp_q.size());
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        send_payload(16'd2, 2, 1'b0);
        send_byte(calc_csum(2), 1'b0);
        tests_run++;
        if ({done, core_rst, err, exp_q.size() == 0} !== 4'b1001) begin
            fails++;
            $display("FAIL reload_after_reset: got done=%b crst=%b err=%b pending=%0d, expected 1 0 0 0",
                     done, core_rst, err, exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic_load();
        test_bad_csum_restart();
        test_bad_len();
        test_full_depth();
        test_gaps_and_hold();
        test_reset_mid_load();
        idle(3);
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end
endmodule
